// File: rtl/wb2axi.sv
// wb2axi -- Wishbone classic (32-bit) slave to single-beat AXI (64-bit) master.
//
// Each Wishbone access becomes exactly one 32-bit AXI read or write. The
// transfer sits in the 64-bit lane that byte-address bit 2 selects. Only one
// transaction is ever in flight, and AW and AR are never issued together.
//
// Ports
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_wb_*               Wishbone classic slave: adr (word address AW-1:2),
//                        dat, sel, we, cyc, stb
//   o_wb_rdt/ack/err     Wishbone read data and termination
//   o_aw*/i_awready      AXI write address channel (size fixed to 4 bytes)
//   o_w*/i_wready        AXI write data channel (data duplicated in both lanes)
//   i_b*/o_bready        AXI write response channel
//   o_ar*/i_arready      AXI read address channel (size fixed to 4 bytes)
//   i_r*/o_rready        AXI read data channel (i_rlast ignored)
module wb2axi #(
  parameter int             AW     = 12,
  parameter int             IW     = 1,
  parameter logic [IW-1:0]  AXI_ID = '0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  // Wishbone slave
  input  logic [AW-1:2] i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic          o_wb_err,
  // AXI write address
  output logic [AW-1:0] o_awaddr,
  output logic [IW-1:0] o_awid,
  output logic [2:0]    o_awsize,
  output logic          o_awvalid,
  input  logic          i_awready,
  // AXI write data
  output logic [63:0]   o_wdata,
  output logic [7:0]    o_wstrb,
  output logic          o_wvalid,
  input  logic          i_wready,
  // AXI write response
  input  logic [1:0]    i_bresp,
  input  logic          i_bvalid,
  output logic          o_bready,
  // AXI read address
  output logic [AW-1:0] o_araddr,
  output logic [IW-1:0] o_arid,
  output logic [2:0]    o_arsize,
  output logic          o_arvalid,
  input  logic          i_arready,
  // AXI read data
  input  logic [63:0]   i_rdata,
  input  logic [1:0]    i_rresp,
  input  logic          i_rlast,
  input  logic          i_rvalid,
  output logic          o_rready
);

  typedef enum logic [2:0] {
    IDLE, WADDR, WRESP, RADDR, RRESP, DONE
  } state_t;

  state_t        state, state_d;
  logic          awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic          ack_d, err_d;
  logic [31:0]   rdt_d;
  logic [AW-1:0] awaddr_d, araddr_d;
  logic [63:0]   wdata_d;
  logic [7:0]    wstrb_d;

  assign o_awid   = AXI_ID;
  assign o_arid   = AXI_ID;
  assign o_awsize = 3'b010;
  assign o_arsize = 3'b010;

  // Single-beat bridge: last-beat flag and the low response bit
  // (OKAY vs EXOKAY, SLVERR vs DECERR) carry no information here.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, i_rlast, i_bresp[0], i_rresp[0]};

  // NOTE: every signal computed here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    awvalid_d = o_awvalid;
    wvalid_d  = o_wvalid;
    bready_d  = o_bready;
    arvalid_d = o_arvalid;
    rready_d  = o_rready;
    rdt_d     = o_wb_rdt;
    awaddr_d  = o_awaddr;
    araddr_d  = o_araddr;
    wdata_d   = o_wdata;
    wstrb_d   = o_wstrb;
    // Terminations are one-cycle pulses: they default low every cycle.
    ack_d     = 1'b0;
    err_d     = 1'b0;

    case (state)
      IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          if (i_wb_we) begin
            awaddr_d = {i_wb_adr, 2'b00};
            if (i_wb_sel != 4'h0) begin
              wdata_d   = {i_wb_dat, i_wb_dat};
              wstrb_d   = i_wb_adr[2] ? {i_wb_sel, 4'h0} : {4'h0, i_wb_sel};
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
              state_d   = WADDR;
            end else begin
              // A write that enables no bytes has nothing to send; finish locally.
              ack_d   = 1'b1;
              state_d = DONE;
            end
          end else begin
            araddr_d  = {i_wb_adr, 2'b00};
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end
        end
      end

      WADDR: begin
        // AW and W complete independently; each valid drops on its own ready.
        if (i_awready) awvalid_d = 1'b0;
        if (i_wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end

      WRESP: begin
        if (i_bvalid && o_bready) begin
          bready_d = 1'b0;
          // A master that dropped cyc has abandoned the cycle: stay silent.
          err_d    = i_bresp[1] & i_wb_cyc;
          ack_d    = ~i_bresp[1] & i_wb_cyc;
          state_d  = DONE;
        end
      end

      RADDR: begin
        if (i_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RRESP;
        end
      end

      RRESP: begin
        if (i_rvalid && o_rready) begin
          rready_d = 1'b0;
          rdt_d    = o_araddr[2] ? i_rdata[63:32] : i_rdata[31:0];
          err_d    = i_rresp[1] & i_wb_cyc;
          ack_d    = ~i_rresp[1] & i_wb_cyc;
          state_d  = DONE;
        end
      end

      // The termination is visible for this one cycle. The strobe is ignored
      // here because the master still holds it until it samples ack.
      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // the values from before this edge regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      o_awvalid <= 1'b0;
      o_wvalid  <= 1'b0;
      o_bready  <= 1'b0;
      o_arvalid <= 1'b0;
      o_rready  <= 1'b0;
      o_wb_ack  <= 1'b0;
      o_wb_err  <= 1'b0;
      o_wb_rdt  <= '0;
      o_awaddr  <= '0;
      o_araddr  <= '0;
      o_wdata   <= '0;
      o_wstrb   <= '0;
    end else begin
      state     <= state_d;
      o_awvalid <= awvalid_d;
      o_wvalid  <= wvalid_d;
      o_bready  <= bready_d;
      o_arvalid <= arvalid_d;
      o_rready  <= rready_d;
      o_wb_ack  <= ack_d;
      o_wb_err  <= err_d;
      o_wb_rdt  <= rdt_d;
      o_awaddr  <= awaddr_d;
      o_araddr  <= araddr_d;
      o_wdata   <= wdata_d;
      o_wstrb   <= wstrb_d;
    end
  end

endmodule

// File: tb/tb_wb2axi.sv
// Directed testbench for wb2axi. The AXI slave side is driven step by step
// from the single stimulus block, and every expected value is written by hand.
module tb_wb2axi;

  localparam int AW = 12;
  localparam int IW = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:2] wb_adr;
  logic [31:0]   wb_dat;
  logic [3:0]    wb_sel;
  logic          wb_we, wb_cyc, wb_stb;
  logic [31:0]   wb_rdt;
  logic          wb_ack, wb_err;
  logic [AW-1:0] awaddr, araddr;
  logic [IW-1:0] awid, arid;
  logic [2:0]    awsize, arsize;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, rlast;
  logic [63:0]   wdata, rdata;
  logic [7:0]    wstrb;
  logic [1:0]    bresp, rresp;

  int n_tests = 0;
  int n_fail  = 0;

  wb2axi #(.AW(AW), .IW(IW), .AXI_ID(1'b0)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_wb_adr (wb_adr),
    .i_wb_dat (wb_dat),
    .i_wb_sel (wb_sel),
    .i_wb_we  (wb_we),
    .i_wb_cyc (wb_cyc),
    .i_wb_stb (wb_stb),
    .o_wb_rdt (wb_rdt),
    .o_wb_ack (wb_ack),
    .o_wb_err (wb_err),
    .o_awaddr (awaddr),
    .o_awid   (awid),
    .o_awsize (awsize),
    .o_awvalid(awvalid),
    .i_awready(awready),
    .o_wdata  (wdata),
    .o_wstrb  (wstrb),
    .o_wvalid (wvalid),
    .i_wready (wready),
    .i_bresp  (bresp),
    .i_bvalid (bvalid),
    .o_bready (bready),
    .o_araddr (araddr),
    .o_arid   (arid),
    .o_arsize (arsize),
    .o_arvalid(arvalid),
    .i_arready(arready),
    .i_rdata  (rdata),
    .i_rresp  (rresp),
    .i_rlast  (rlast),
    .i_rvalid (rvalid),
    .o_rready (rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then settle away from the edge before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_start(input logic we, input logic [AW-1:2] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
    wb_we  = we;
    wb_adr = adr;
    wb_dat = dat;
    wb_sel = sel;
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
  endtask

  task automatic wb_stop();
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wb_adr = '0; wb_dat = '0; wb_sel = '0; wb_we = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
    tick();
    tick();

    // ---- reset state ----
    check("rst_awvalid", 64'(awvalid), 64'd0);
    check("rst_wvalid",  64'(wvalid),  64'd0);
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_bready",  64'(bready),  64'd0);
    check("rst_rready",  64'(rready),  64'd0);
    check("rst_ack",     64'(wb_ack),  64'd0);
    check("rst_err",     64'(wb_err),  64'd0);
    check("rst_rdt",     64'(wb_rdt),  64'd0);
    check("rst_awaddr",  64'(awaddr),  64'd0);
    check("rst_wdata",   wdata,        64'd0);
    check("rst_wstrb",   64'(wstrb),   64'd0);
    check("const_awsize", 64'(awsize), 64'd2);
    check("const_arsize", 64'(arsize), 64'd2);
    check("const_awid",   64'(awid),   64'd0);
    check("const_arid",   64'(arid),   64'd0);
    rst = 1'b0;
    tick();

    // ---- write, zero wait states, high lane ----
    awready = 1'b1; wready = 1'b1;
    wb_start(1'b1, 10'h001, 32'hA5A5_1234, 4'hF);
    tick();
    check("w1_awvalid", 64'(awvalid), 64'd1);
    check("w1_wvalid",  64'(wvalid),  64'd1);
    check("w1_awaddr",  64'(awaddr),  64'h004);
    check("w1_wstrb",   64'(wstrb),   64'hF0);
    check("w1_wdata_hi", 64'(wdata[63:32]), 64'hA5A5_1234);
    check("w1_arvalid", 64'(arvalid), 64'd0);
    check("w1_ack_early", 64'(wb_ack), 64'd0);
    tick();
    check("w1_valids_done", 64'({awvalid, wvalid}), 64'd0);
    check("w1_bready",  64'(bready),  64'd1);
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    check("w1_ack",    64'(wb_ack),  64'd1);
    check("w1_err",    64'(wb_err),  64'd0);
    check("w1_bready_clr", 64'(bready), 64'd0);
    bvalid = 1'b0;
    // Master keeps stb high through the ack cycle; it must not be re-accepted.
    tick();
    check("w1_ack_pulse", 64'(wb_ack),  64'd0);
    check("w1_no_reissue", 64'(awvalid), 64'd0);
    wb_stop();
    tick();
    check("w1_idle_awvalid", 64'(awvalid), 64'd0);

    // ---- read, low lane ----
    arready = 1'b1;
    wb_start(1'b0, 10'h002, 32'h0, 4'hF);
    tick();
    check("r1_arvalid", 64'(arvalid), 64'd1);
    check("r1_araddr",  64'(araddr),  64'h008);
    check("r1_awvalid", 64'(awvalid), 64'd0);
    tick();
    check("r1_arvalid_clr", 64'(arvalid), 64'd0);
    check("r1_rready", 64'(rready), 64'd1);
    rvalid = 1'b1; rdata = 64'h1111_2222_3333_4444; rresp = 2'b00; rlast = 1'b1;
    tick();
    check("r1_ack",    64'(wb_ack), 64'd1);
    check("r1_err",    64'(wb_err), 64'd0);
    check("r1_rdt",    64'(wb_rdt), 64'h3333_4444);
    check("r1_rready_clr", 64'(rready), 64'd0);
    rvalid = 1'b0;
    wb_stop();
    tick();
    check("r1_ack_pulse", 64'(wb_ack), 64'd0);

    // ---- read, high lane ----
    wb_start(1'b0, 10'h003, 32'h0, 4'hF);
    tick();
    check("r2_araddr", 64'(araddr), 64'h00C);
    tick();
    rvalid = 1'b1; rdata = 64'h1111_2222_3333_4444;
    tick();
    check("r2_ack", 64'(wb_ack), 64'd1);
    check("r2_rdt", 64'(wb_rdt), 64'h1111_2222);
    rvalid = 1'b0;
    wb_stop();
    tick();

    // ---- write with AW delayed four cycles, W immediate ----
    awready = 1'b0; wready = 1'b1;
    wb_start(1'b1, 10'h004, 32'hDEAD_BEEF, 4'h3);
    tick();
    check("w2_awvalid0", 64'(awvalid), 64'd1);
    check("w2_wvalid0",  64'(wvalid),  64'd1);
    check("w2_wstrb",    64'(wstrb),   64'h03);
    check("w2_wdata",    wdata,        64'hDEAD_BEEF_DEAD_BEEF);
    tick();
    check("w2_wvalid_clr", 64'(wvalid),  64'd0);
    check("w2_awvalid1",   64'(awvalid), 64'd1);
    check("w2_bready_wait", 64'(bready), 64'd0);
    tick();
    check("w2_awvalid2", 64'(awvalid), 64'd1);
    check("w2_awaddr_stable", 64'(awaddr), 64'h010);
    tick();
    check("w2_awvalid3", 64'(awvalid), 64'd1);
    check("w2_ack_wait", 64'(wb_ack), 64'd0);
    awready = 1'b1;
    tick();
    check("w2_awvalid_clr", 64'(awvalid), 64'd0);
    check("w2_bready", 64'(bready), 64'd1);
    check("w2_wstrb_stable", 64'(wstrb), 64'h03);
    awready = 1'b0;
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    check("w2_ack", 64'(wb_ack), 64'd1);
    bvalid = 1'b0;
    wb_stop();
    tick();
    check("w2_ack_pulse", 64'(wb_ack), 64'd0);

    // ---- read with SLVERR, high lane ----
    arready = 1'b1;
    wb_start(1'b0, 10'h005, 32'h0, 4'hF);
    tick();
    tick();
    check("r3_rready", 64'(rready), 64'd1);
    rvalid = 1'b1; rdata = 64'hCAFE_F00D_0BAD_BEEF; rresp = 2'b10;
    tick();
    check("r3_err", 64'(wb_err), 64'd1);
    check("r3_ack", 64'(wb_ack), 64'd0);
    check("r3_rdt", 64'(wb_rdt), 64'hCAFE_F00D);
    rvalid = 1'b0; rresp = 2'b00;
    wb_stop();
    tick();
    check("r3_err_pulse", 64'(wb_err), 64'd0);

    // ---- write with DECERR ----
    awready = 1'b1; wready = 1'b1;
    wb_start(1'b1, 10'h000, 32'h0102_0304, 4'hF);
    tick();
    check("w3_wstrb", 64'(wstrb), 64'h0F);
    tick();
    bvalid = 1'b1; bresp = 2'b11;
    tick();
    check("w3_err", 64'(wb_err), 64'd1);
    check("w3_ack", 64'(wb_ack), 64'd0);
    check("w3_rdt_hold", 64'(wb_rdt), 64'hCAFE_F00D);
    bvalid = 1'b0; bresp = 2'b00;
    wb_stop();
    tick();
    check("w3_err_pulse", 64'(wb_err), 64'd0);

    // ---- write with no byte selects: local ack, no AXI traffic ----
    awready = 1'b0; wready = 1'b0;
    wb_start(1'b1, 10'h007, 32'hFFFF_FFFF, 4'h0);
    tick();
    check("w4_ack", 64'(wb_ack), 64'd1);
    check("w4_no_valid", 64'({awvalid, wvalid}), 64'd0);
    wb_stop();
    tick();
    check("w4_ack_pulse", 64'(wb_ack), 64'd0);
    check("w4_still_no_valid", 64'({awvalid, wvalid}), 64'd0);

    // ---- cyc dropped during RADDR: AXI completes, no termination ----
    arready = 1'b0;
    wb_start(1'b0, 10'h006, 32'h0, 4'hF);
    tick();
    check("ab_arvalid", 64'(arvalid), 64'd1);
    wb_stop();
    tick();
    check("ab_arvalid_held", 64'(arvalid), 64'd1);
    arready = 1'b1;
    tick();
    check("ab_rready", 64'(rready), 64'd1);
    arready = 1'b0;
    rvalid = 1'b1; rdata = 64'h5555_6666_7777_8888;
    tick();
    check("ab_rready_clr", 64'(rready), 64'd0);
    check("ab_no_term", 64'({wb_ack, wb_err}), 64'd0);
    rvalid = 1'b0;
    tick();
    check("ab_idle_term", 64'({wb_ack, wb_err}), 64'd0);
    check("ab_idle_arvalid", 64'(arvalid), 64'd0);

    // ---- reset in WADDR, then a normal read ----
    awready = 1'b0; wready = 1'b0;
    wb_start(1'b1, 10'h001, 32'h1234_5678, 4'hF);
    tick();
    check("rs_awvalid", 64'(awvalid), 64'd1);
    rst = 1'b1;
    wb_stop();
    tick();
    check("rs_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
    check("rs_term", 64'({wb_ack, wb_err}), 64'd0);
    check("rs_rdt", 64'(wb_rdt), 64'd0);
    rst = 1'b0;
    arready = 1'b1;
    wb_start(1'b0, 10'h003, 32'h0, 4'hF);
    tick();
    check("rs_r_arvalid", 64'(arvalid), 64'd1);
    check("rs_r_araddr", 64'(araddr), 64'h00C);
    tick();
    rvalid = 1'b1; rdata = 64'h9ABC_DEF0_0FED_CBA9; rresp = 2'b00;
    tick();
    check("rs_r_ack", 64'(wb_ack), 64'd1);
    check("rs_r_rdt", 64'(wb_rdt), 64'h9ABC_DEF0);
    rvalid = 1'b0;
    wb_stop();
    tick();
    check("rs_r_ack_pulse", 64'(wb_ack), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb2axi.md
Name: wb2axi

Overview:
- Wishbone classic 32-bit slave to AXI (lite-style, single-beat) 64-bit master bridge.
- It is the initiator-side counterpart of the AXI-to-Wishbone bridge. It lets Wishbone masters (CPU data port, debug) reach AXI-attached memory and peripherals.
- One transaction in flight. Each Wishbone access becomes exactly one 32-bit AXI read or write on a 64-bit bus, placed in the lane selected by address bit 2.

Parameters:
- AW, 12, byte address width of AXI side; Wishbone address is AW-1:2.
- IW, 1, AXI ID width (minimum 1).
- AXI_ID, 0, constant ID driven on o_awid/o_arid.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_wb_adr  in  AW-2  Wishbone word address.
- i_wb_dat  in  32  write data.
- i_wb_sel  in  4  byte selects.
- i_wb_we  in  1  write enable.
- i_wb_cyc  in  1  cycle valid.
- i_wb_stb  in  1  strobe.
- o_wb_rdt  out  32  read data.
- o_wb_ack  out  1  normal termination.
- o_wb_err  out  1  error termination.
- o_awaddr  out  AW  write address.
- o_awid  out  IW  write ID.
- o_awsize  out  3  write size.
- o_awvalid  out  1  write address valid.
- i_awready  in  1  write address ready.
- o_wdata  out  64  write data.
- o_wstrb  out  8  write strobes.
- o_wvalid  out  1  write data valid.
- i_wready  in  1  write data ready.
- i_bresp  in  2  write response code.
- i_bvalid  in  1  write response valid.
- o_bready  out  1  write response ready.
- o_araddr  out  AW  read address.
- o_arid  out  IW  read ID.
- o_arsize  out  3  read size.
- o_arvalid  out  1  read address valid.
- i_arready  in  1  read address ready.
- i_rdata  in  64  read data.
- i_rresp  in  2  read response code.
- i_rlast  in  1  last beat.
- i_rvalid  in  1  read data valid.
- o_rready  out  1  read data ready.

Behaviour:
- Reset (i_rst=1 at clock edge) drives:
  - o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_wb_ack, o_wb_err = 0.
  - o_wb_rdt = 0, all AXI address/data/strobe outputs = 0, state = IDLE.
  - Reset mid-transaction abandons it immediately; reset is system-wide, so the AXI slave is reset too.
- Constants: o_awid = o_arid = AXI_ID; o_awsize = o_arsize = 3'b010.
- States: IDLE, WADDR, WRESP, RADDR, RRESP, DONE.
- IDLE:
  - Acts only when i_wb_cyc & i_wb_stb.
  - Latches address; o_awaddr or o_araddr = {i_wb_adr, 2'b00}.
  - Write with i_wb_sel != 0:
    - o_wdata = {i_wb_dat, i_wb_dat}.
    - o_wstrb = i_wb_adr[2] ? {sel, 4'h0} : {4'h0, sel}.
    - o_awvalid = o_wvalid = 1 on the next cycle; go to WADDR.
  - Write with i_wb_sel == 0: no AXI traffic; o_wb_ack = 1 next cycle; go to DONE.
  - Read: o_arvalid = 1; go to RADDR.
- WADDR:
  - o_awvalid clears on i_awready; o_wvalid clears on i_wready. The two handshakes are independent and may complete in either order or the same cycle.
  - Valids hold and payload stays stable until accepted.
  - Once both are done: o_bready = 1; go to WRESP.
- WRESP:
  - On i_bvalid & o_bready: o_bready = 0.
  - o_wb_err = i_bresp[1]; o_wb_ack = ~i_bresp[1]. Go to DONE.
- RADDR: on i_arready, o_arvalid = 0, o_rready = 1; go to RRESP.
- RRESP:
  - On i_rvalid & o_rready: o_rready = 0.
  - o_wb_rdt = latched adr[2] ? i_rdata[63:32] : i_rdata[31:0].
  - o_wb_err = i_rresp[1]; o_wb_ack = ~i_rresp[1]. Go to DONE.
  - i_rlast is ignored (single beat).
- DONE:
  - ack/err are high for exactly this one cycle, then clear; return to IDLE.
  - Wishbone stb is ignored in DONE, so the still-high stb is not re-accepted.
  - Minimum Wishbone latency: 3 cycles from stb to ack, when the AXI slave responds with zero wait states.
- Abort: if i_wb_cyc drops while an AXI transaction is in flight, the AXI transaction still completes (valid never withdrawn). ack/err are suppressed if i_wb_cyc = 0 in the response cycle.
- o_wb_rdt holds its last read value across writes and idle cycles.
- o_wb_ack and o_wb_err are never high in the same cycle.
- Never more than one AXI transaction outstanding; never AW and AR simultaneously.

Test Plan:
- Write adr=0x01 (byte 0x004), dat=0xA5A5_1234, sel=0xF, AXI ready always high, bresp=0 -> awaddr=0x004, wstrb=0xF0, wdata[63:32]=0xA5A5_1234, one-cycle ack 3 cycles after stb.
- Read adr=0x02 (byte 0x008), rdata=0x1111_2222_3333_4444, rresp=0 -> araddr=0x008, o_wb_rdt=0x3333_4444, ack; then read adr=0x03 -> 0x1111_2222.
- Write with i_awready delayed 4 cycles and i_wready immediate -> o_wvalid drops after 1 cycle, o_awvalid held 4 cycles with stable payload, single ack after B.
- Read with rresp=2'b10 -> o_wb_err=1 for one cycle, o_wb_ack stays 0; write with bresp=2'b11 -> o_wb_err.
- Write with sel=0 -> no awvalid/wvalid ever asserted, ack next cycle; cyc dropped during RADDR -> AR and R handshakes complete, no ack/err.
- Assert i_rst during WADDR with valids high -> next cycle all valids, ack, err = 0; new read after reset proceeds normally.
